// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline sequencer (master) and the
// instruction pointer / fetch / decode units around it (slave).
interface pipeline_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic                      run;
  logic                      mem_ack;
  logic        [INSTR_W-1:0] mem_data;
  logic                      dec_done;
  logic        [ADDR_W-1:0]  dec_len;
  logic                      branch_taken;
  logic signed [ADDR_W-1:0]  branch_off;
  logic                      halt_req;

  logic                      do_reset;
  logic                      do_fetch;
  logic                      do_decode;
  logic                      do_next;
  logic        [ADDR_W-1:0]  pc_adj;
  logic        [INSTR_W-1:0] instr_q;
  logic        [2:0]         state;
  logic                      halted;
  logic        [31:0]        retired;
  logic                      fault;

  modport master (
    input  run, mem_ack, mem_data, dec_done, dec_len, branch_taken, branch_off, halt_req,
    output do_reset, do_fetch, do_decode, do_next, pc_adj, instr_q, state, halted,
           retired, fault
  );

  modport slave (
    output run, mem_ack, mem_data, dec_done, dec_len, branch_taken, branch_off, halt_req,
    input  do_reset, do_fetch, do_decode, do_next, pc_adj, instr_q, state, halted,
           retired, fault
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Central CPU control FSM: RST -> IDLE -> FETCH -> DECODE -> NEXT, with HALT.
// Optional fetch timeout fault enabled by defining SEQ_FETCH_TIMEOUT_EN.
module pipeline_sequencer #(
  parameter int ADDR_W        = 16,
  parameter int INSTR_W       = 16,
  parameter int RESET_CYCLES  = 4,
  parameter int FETCH_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

  if (RESET_CYCLES < 1 || RESET_CYCLES > 255 || FETCH_TIMEOUT < 1) begin : g_bad_param
    $error("pipeline_sequencer: RESET_CYCLES or FETCH_TIMEOUT out of range");
  end

  state_t     state_q;
  logic [7:0] rst_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A zero decoded length would pin the PC, so it is promoted to 1.
  function automatic logic [ADDR_W-1:0] adj_sel(input logic                     br,
                                                input logic signed [ADDR_W-1:0] off,
                                                input logic        [ADDR_W-1:0] len);
    if (br)        return $unsigned(off);
    if (len == '0) return ADDR_W'(1);
    return len;
  endfunction

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int             TW        = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0]  WAIT_LAST = TW'(FETCH_TIMEOUT - 1);

  logic [TW-1:0] wait_q;
  logic          fault_q;

  // Zero on the first FETCH cycle, counts each FETCH cycle left unacknowledged.
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_FETCH) wait_q <= '0;
    else if (!bus.mem_ack)            wait_q <= wait_q + 1'b1;
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST;
      rst_cnt_q     <= '0;
      bus.do_reset  <= 1'b1;
      bus.do_fetch  <= 1'b0;
      bus.do_decode <= 1'b0;
      bus.do_next   <= 1'b0;
      bus.pc_adj    <= '0;
      bus.instr_q   <= '0;
      bus.retired   <= '0;
      bus.halted    <= 1'b0;
`ifdef SEQ_FETCH_TIMEOUT_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q      <= ST_IDLE;
            bus.do_reset <= 1'b0;
          end else begin
            rst_cnt_q    <= rst_cnt_q + 8'd1;
          end
        end
        ST_IDLE: begin
          if (bus.run) begin
            state_q      <= ST_FETCH;
            bus.do_fetch <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.mem_ack) begin
            bus.instr_q   <= bus.mem_data;
            bus.do_fetch  <= 1'b0;
            bus.do_decode <= 1'b1;
            state_q       <= ST_DECODE;
          end
`ifdef SEQ_FETCH_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            fault_q      <= 1'b1;
            bus.do_fetch <= 1'b0;
            bus.halted   <= 1'b1;
            state_q      <= ST_HALT;
          end
`endif
        end
        ST_DECODE: begin
          if (bus.dec_done) begin
            bus.pc_adj    <= adj_sel(bus.branch_taken, bus.branch_off, bus.dec_len);
            bus.do_decode <= 1'b0;
            if (bus.halt_req) begin
              bus.halted  <= 1'b1;
              state_q     <= ST_HALT;
            end else begin
              bus.do_next <= 1'b1;
              state_q     <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          bus.do_next <= 1'b0;
          bus.retired <= sat_inc(bus.retired);
          if (bus.run) begin
            bus.do_fetch <= 1'b1;
            state_q      <= ST_FETCH;
          end else begin
            state_q      <= ST_IDLE;
          end
        end
        ST_HALT: begin
        end
        default: begin
          state_q      <= ST_RST;
          rst_cnt_q    <= '0;
          bus.do_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: expected pc_adj/instr_q pairs are
// queued when dec_done is driven and popped on each do_next pulse.
module tb_pipeline_sequencer;
  localparam int ADDR_W        = 16;
  localparam int INSTR_W       = 16;
  localparam int RESET_CYCLES  = 4;
  localparam int FETCH_TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_next = 1'b0;
  logic [31:0] exp_q[$];

  pipeline_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) sif ();

  pipeline_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
    .RESET_CYCLES(RESET_CYCLES), .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(sif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    check_eq("strobe_excl",
             32'((int'(sif.do_reset) + int'(sif.do_fetch) + int'(sif.do_decode)
                  + int'(sif.do_next)) <= 1), 32'd1);
    if (sif.do_next) begin
      check_eq("next_pulse", 32'(prev_next), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_next", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pc_adj", 32'(sif.pc_adj), 32'(e[31:16]));
        check_eq("instr_q", 32'(sif.instr_q), 32'(e[15:0]));
      end
    end
    prev_next = sif.do_next;
  end

  task automatic check_reset_vals(input string p);
    check_eq({p, "_state"}, 32'(sif.state), 32'd0);
    check_eq({p, "_do_reset"}, 32'(sif.do_reset), 32'd1);
    check_eq({p, "_strobes"}, 32'({sif.do_fetch, sif.do_decode, sif.do_next}), 32'd0);
    check_eq({p, "_pc_adj"}, 32'(sif.pc_adj), 32'd0);
    check_eq({p, "_instr_q"}, 32'(sif.instr_q), 32'd0);
    check_eq({p, "_retired"}, sif.retired, 32'd0);
    check_eq({p, "_flags"}, 32'({sif.halted, sif.fault}), 32'd0);
  endtask

  task automatic release_reset(input string p);
    int n = 0;
    reset = 1'b0;
    for (int i = 0; i < 20 && sif.do_reset; i++) begin
      n++;
      step();
    end
    check_eq({p, "_reset_len"}, 32'(n), 32'(RESET_CYCLES));
    check_eq({p, "_idle"}, 32'(sif.state), 32'd1);
    check_eq({p, "_idle_out"},
             32'({sif.do_fetch, sif.do_decode, sif.do_next, sif.halted, sif.fault}), 32'd0);
  endtask

  task automatic wait_fetch(output int t);
    for (int i = 0; i < 50 && !sif.do_fetch; i++) step();
    if (!sif.do_fetch) check_eq("fetch_wait", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic run_instr(input logic [15:0] data, input logic [15:0] len, input logic br,
                           input logic [15:0] off, input logic hlt, input int waits,
                           input logic drop_run, output int t_fetch);
    int nf = 0;
    int others = 0;
    logic [15:0] adj;
    wait_fetch(t_fetch);
    sif.mem_ack = 1'b0;
    for (int w = 0; w < waits; w++) begin
      if (sif.do_fetch) nf++;
      if (sif.do_reset || sif.do_decode || sif.do_next) others++;
      step();
    end
    if (sif.do_fetch) nf++;
    sif.mem_ack  = 1'b1;
    sif.mem_data = data;
    step();
    sif.mem_ack  = 1'b0;
    sif.mem_data = 16'($urandom);
    check_eq("fetch_cycles", 32'(nf), 32'(waits + 1));
    check_eq("fetch_others", 32'(others), 32'd0);
    check_eq("decode_en", 32'(sif.do_decode), 32'd1);
    sif.dec_done     = 1'b1;
    sif.dec_len      = len;
    sif.branch_taken = br;
    sif.branch_off   = off;
    sif.halt_req     = hlt;
    if (drop_run) sif.run = 1'b0;
    adj = br ? off : ((len == 16'd0) ? 16'd1 : len);
    if (!hlt) exp_q.push_back({adj, data});
    step();
    sif.dec_done     = 1'b0;
    sif.branch_taken = 1'b0;
    sif.halt_req     = 1'b0;
    sif.dec_len      = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t;
    int n;
    sif.run = 1'b0; sif.mem_ack = 1'b0; sif.mem_data = '0; sif.dec_done = 1'b0;
    sif.dec_len = '0; sif.branch_taken = 1'b0; sif.branch_off = '0; sif.halt_req = 1'b0;

    reset = 1'b1;
    step(); step(); step();
    check_reset_vals("rst0");
    release_reset("rst0");

    // Three back-to-back zero-wait instructions.
    sif.run = 1'b1;
    run_instr(16'hA55A, 16'd2, 1'b0, 16'h0, 1'b0, 0, 1'b0, t0);
    run_instr(16'hA55A, 16'd2, 1'b0, 16'h0, 1'b0, 0, 1'b0, t);
    run_instr(16'hA55A, 16'd2, 1'b0, 16'h0, 1'b0, 0, 1'b0, t);
    check_eq("three_instr_cycles", 32'(cyc - t0 + 1), 32'd9);
    step();
    check_eq("retired_3", sif.retired, 32'd3);

    run_instr(16'h1234, 16'd3, 1'b1, 16'hFFFC, 1'b0, 0, 1'b0, t);
    run_instr(16'h0F0F, 16'd0, 1'b0, 16'h7777, 1'b0, 0, 1'b0, t);

    // Slow memory, and run dropped while decoding.
    run_instr(16'hBEEF, 16'd4, 1'b0, 16'h0, 1'b0, 5, 1'b1, t);
    step();
    check_eq("drop_run_idle", 32'(sif.state), 32'd1);
    step(); step(); step();
    check_eq("stay_idle", 32'({sif.state, sif.do_fetch}), 32'({3'd1, 1'b0}));
    check_eq("retired_6", sif.retired, 32'd6);

    sif.run = 1'b1;
    run_instr(16'hDEAD, 16'd2, 1'b0, 16'h0, 1'b1, 0, 1'b0, t);
    check_eq("halt_state", 32'(sif.state), 32'd5);
    check_eq("halt_flag", 32'(sif.halted), 32'd1);
    check_eq("halt_retired", sif.retired, 32'd6);
    step(); step(); step();
    check_eq("halt_stays", 32'({sif.state, sif.do_next, sif.do_fetch}), 32'({3'd5, 2'b00}));
    check_eq("halt_pc_adj", 32'(sif.pc_adj), 32'd2);
    check_eq("halt_retired2", sif.retired, 32'd6);

    reset = 1'b1;
    step();
    check_reset_vals("rst_halt");
    step();
    release_reset("rst_halt");

    // Reset landing mid-FETCH.
    sif.run = 1'b1;
    wait_fetch(t);
    step(); step();
    check_eq("fetch_held", 32'(sif.state), 32'd2);
    reset = 1'b1;
    step();
    check_reset_vals("rst_fetch");
    release_reset("rst_fetch");

`ifdef SEQ_FETCH_TIMEOUT_EN
    wait_fetch(t);
    n = 0;
    for (int i = 0; i < 40 && sif.state == 3'd2; i++) begin
      n++;
      step();
    end
    check_eq("to_fetch_cycles", 32'(n), 32'(FETCH_TIMEOUT));
    check_eq("to_state", 32'(sif.state), 32'd5);
    check_eq("to_fault", 32'(sif.fault), 32'd1);
    check_eq("to_halted", 32'(sif.halted), 32'd1);
    check_eq("to_retired", sif.retired, 32'd0);
    step(); step();
    check_eq("to_fault_sticky", 32'(sif.fault), 32'd1);
    reset = 1'b1;
    step();
    check_reset_vals("rst_to");
    release_reset("rst_to");
    run_instr(16'h5A5A, 16'd2, 1'b0, 16'h0, 1'b0, FETCH_TIMEOUT - 1, 1'b0, t);
    step();
    check_eq("late_ack_fault", 32'(sif.fault), 32'd0);
    check_eq("late_ack_retired", sif.retired, 32'd1);
`else
    n = 0;
    run_instr(16'h5A5A, 16'd2, 1'b0, 16'h0, 1'b0, 20, 1'b0, t);
    step();
    check_eq("long_wait_fault", 32'(sif.fault), 32'd0);
    check_eq("long_wait_retired", sif.retired, 32'd1 + 32'(n));
`endif

    sif.run = 1'b0;
    step(); step(); step(); step();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
